// File: rtl/weight_load_ctrl_pkg.sv
// ============================================================================
// Module   : wlc_pkg
// Purpose  : Shared constants, state type and helpers for weight_load_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wlc_pkg;

  localparam int COLS     = 3;
  localparam int WEIGHT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    FILL   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } wlc_state_e;

  // Pops needed to drain one tile through the column skew.
  function automatic int stream_len(input int rows);
    return rows + COLS - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_load_ctrl.sv
// ============================================================================
// Module   : weight_load_ctrl
// Purpose  : Loads one ROWS x 3 weight tile into the 3-column weight FIFO,
//            then issues the skewed pop burst and MMU capture window.
//            Optional perf counters are enabled by defining WLC_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_load_ctrl
  import wlc_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
`ifdef WLC_PERF_CNT_EN
  output logic [CNT_W-1:0]    tile_count,
  output logic [CNT_W-1:0]    stall_count,
`endif
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [WEIGHT_W-1:0] w_data,
  output logic                push_col0,
  output logic                push_col1,
  output logic                push_col2,
  output logic [WEIGHT_W-1:0] fifo_data,
  output logic                pop,
  output logic                mmu_load_en,
  output logic [2:0]          load_cycle
);

  localparam int BYTES  = COLS * ROWS;
  localparam int SLEN   = stream_len(ROWS);
  localparam int BYTE_W = $clog2(BYTES + 1);
  // Pad debt never exceeds COLS-1, which is below DEPTH.
  localparam int PAD_W  = $clog2(DEPTH);

  wlc_state_e         r_state;
  wlc_state_e         w_next;
  logic [PAD_W-1:0]   r_pad_debt;
  logic [BYTE_W-1:0]  r_byte_cnt;
  logic [1:0]         r_col;
  logic [2:0]         r_strm_cnt;
  logic [COLS-1:0]    w_push;
  logic               w_last_byte;
  logic               w_last_pop;

  assign w_last_byte = (r_byte_cnt == BYTE_W'(BYTES - 1));
  assign w_last_pop  = (r_strm_cnt == 3'(SLEN - 1));

  assign push_col0 = w_push[0];
  assign push_col1 = w_push[1];
  assign push_col2 = w_push[2];

  always_comb begin
    w_next      = r_state;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    w_ready     = 1'b0;
    w_push      = '0;
    fifo_data   = '0;
    pop         = 1'b0;
    mmu_load_en = 1'b0;
    load_cycle  = '0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (r_pad_debt != '0) ? ALIGN : FILL;
      end
      ALIGN: begin
        // Zero pad pushes bring the write pointers level with the read side.
        w_push = '1;
        if (r_pad_debt <= PAD_W'(1)) w_next = FILL;
      end
      FILL: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_push[r_col] = 1'b1;
          fifo_data     = w_data;
          if (w_last_byte) w_next = STREAM;
        end
      end
      STREAM: begin
        pop         = 1'b1;
        mmu_load_en = 1'b1;
        load_cycle  = r_strm_cnt;
        if (w_last_pop) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pad_debt <= '0;
      r_byte_cnt <= '0;
      r_col      <= '0;
      r_strm_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ALIGN: r_pad_debt <= r_pad_debt - PAD_W'(1);
        FILL: begin
          if (w_valid) begin
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_col      <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
              r_col      <= (r_col == 2'(COLS - 1)) ? 2'd0 : r_col + 2'd1;
            end
          end
        end
        STREAM: r_strm_cnt <= w_last_pop ? 3'd0 : r_strm_cnt + 3'd1;
        DONE:   r_pad_debt <= PAD_W'(COLS - 1);
        default: ;
      endcase
    end
  end

`ifdef WLC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_count  <= '0;
      stall_count <= '0;
    end else begin
      if (r_state == DONE && tile_count != '1)
        tile_count <= tile_count + CNT_W'(1);
      if (r_state == FILL && !w_valid && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] w_unused_perf;
  assign w_unused_perf = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
// ============================================================================
// Module   : tb_weight_load_ctrl
// Purpose  : Self-checking bench for weight_load_ctrl with a push-event
//            scoreboard and a behavioural 3-column skewed FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_load_ctrl;
  import wlc_pkg::*;

  localparam int ROWS  = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int NB    = 3 * ROWS;
  localparam int SLEN  = ROWS + 2;

  logic       clk = 1'b0;
  logic       rst, start, w_valid;
  logic [7:0] w_data;
  logic       busy, done, w_ready, push_col0, push_col1, push_col2;
  logic       pop, mmu_load_en;
  logic [7:0] fifo_data;
  logic [2:0] load_cycle;
`ifdef WLC_PERF_CNT_EN
  logic [CNT_W-1:0] tile_count, stall_count;
`endif

  weight_load_ctrl #(.ROWS(ROWS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
`ifdef WLC_PERF_CNT_EN
    .tile_count(tile_count), .stall_count(stall_count),
`endif
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .push_col0(push_col0), .push_col1(push_col1), .push_col2(push_col2),
    .fifo_data(fifo_data), .pop(pop), .mmu_load_en(mmu_load_en),
    .load_cycle(load_cycle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected push events in order: pad events hit all columns with data 0.
  typedef struct packed { logic [2:0] mask; logic [7:0] data; } push_ev_t;
  push_ev_t   exp_q[$];
  logic [7:0] cur_tile[NB];

  // Behavioural FIFO: per-column ring buffers with independent pointers.
  logic [7:0] mem[3][DEPTH];
  int         wp[3], rp[3];
  logic [7:0] raw[3][SLEN];
  logic [7:0] log_col[3][ROWS];
  int         log_n[3];

  int run_idx = 0, done_cnt = 0, n_align = 0, n_push = 0, n_pop = 0;
  int tiles_m = 0, stalls_m = 0;
  logic [2:0] pv;
  push_ev_t   ev;
  int         j;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin wp[c] = 0; rp[c] = 0; end
      run_idx = 0; tiles_m = 0; stalls_m = 0;
    end else begin
      pv = {push_col2, push_col1, push_col0};
      chk("busy", busy, w_ready | pop | done | (&pv));
      chk("mmu_eq_pop", mmu_load_en, pop);
      if (w_ready) begin
        chk("push_iff_valid", |pv, w_valid);
        if (!w_valid) stalls_m++;
      end
      if (pv == 3'b000) chk("bus_idle_zero", fifo_data, 0);
      else begin
        if (pv == 3'b111) n_align++;
        else begin
          n_push++;
          chk("push_in_fill", w_ready & w_valid, 1);
        end
        if (exp_q.size() == 0) chk("unexpected_push", pv, 0);
        else begin
          ev = exp_q.pop_front();
          chk("push_mask", pv, ev.mask);
          chk("push_data", fifo_data, ev.data);
        end
        for (int c = 0; c < 3; c++) if (pv[c]) begin
          mem[c][wp[c] % DEPTH] = fifo_data;
          wp[c]++;
          if (pv != 3'b111 && log_n[c] < ROWS) begin
            log_col[c][log_n[c]] = fifo_data;
            log_n[c]++;
          end
        end
      end
      if (pop) begin
        n_pop++;
        chk("load_cycle", load_cycle, run_idx);
        for (int c = 0; c < 3; c++) begin
          if (run_idx < SLEN) raw[c][run_idx] = mem[c][rp[c] % DEPTH];
          rp[c]++;
        end
        // Column c output is delayed c pops by the skew stage.
        for (int c = 0; c < 3; c++) begin
          j = run_idx - c;
          if (j >= 0 && j < ROWS && run_idx < SLEN)
            chk("fifo_skew_out", raw[c][j], cur_tile[j*3 + c]);
        end
        run_idx++;
      end else begin
        chk("load_cycle_idle", load_cycle, 0);
        if (run_idx > 0) begin
          chk("stream_len", run_idx, SLEN);
          chk("done_after_stream", done, 1);
          run_idx = 0;
        end else chk("done_spurious", done, 0);
      end
      if (done) begin done_cnt++; tiles_m++; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prep(input logic [7:0] base, input bit pad);
    push_ev_t e;
    for (int k = 0; k < NB; k++) cur_tile[k] = base + 8'(k);
    if (pad) begin
      e.mask = 3'b111; e.data = 8'd0;
      exp_q.push_back(e); exp_q.push_back(e);
    end
    for (int k = 0; k < NB; k++) begin
      e.mask = 3'(1 << (k % 3)); e.data = base + 8'(k);
      exp_q.push_back(e);
    end
    for (int c = 0; c < 3; c++) log_n[c] = 0;
    n_align = 0; n_push = 0; n_pop = 0;
  endtask

  task automatic feed(input int nbytes, input bit gaps);
    int idx = 0, cyc = 0;
    bit hs;
    while (idx < nbytes && cyc < 100) begin
      w_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      w_data  = cur_tile[idx];
      @(negedge clk);
      hs = w_valid && w_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    chk("fill_bytes", idx, nbytes);
  endtask

  task automatic load_tile(input logic [7:0] base, input bit pad, input bit gaps, input bit hold);
    int d0, cyc;
    prep(base, pad);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    feed(NB, gaps);
    w_valid = 1'b0; w_data = 8'd0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 50) begin tick(); cyc++; end
    start = 1'b0;
    repeat (3) tick();
    chk("single_done", done_cnt - d0, 1);
    chk("idle_after_tile", busy, 0);
    chk("align_cycles", n_align, pad ? 2 : 0);
    chk("data_pushes", n_push, NB);
    chk("pop_cycles", n_pop, SLEN);
    chk("leftover_events", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, w_ready, 0);
    chk({tag, "_push"}, {push_col2, push_col1, push_col0}, 0);
    chk({tag, "_data"}, fifo_data, 0);
    chk({tag, "_pop"}, {pop, mmu_load_en}, 0);
    chk({tag, "_lcyc"}, load_cycle, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int col_ref[3][ROWS] = '{'{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9}};

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Tile 1: no pad, back-to-back bytes 1..9.
    load_tile(8'd1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < ROWS; r++)
        chk("col_route_lit", log_col[c][r], col_ref[c][r]);

    // Tile 2: two pad cycles, then bytes 11..19.
    load_tile(8'd11, 1'b1, 1'b0, 1'b0);
    chk("col2_first_lit", log_col[2][0], 13);

    // Tile 3: valid toggling.
    load_tile(8'd21, 1'b1, 1'b1, 1'b0);

    // Tile 4: start held high throughout.
    load_tile(8'd31, 1'b1, 1'b0, 1'b1);
    chk("done_total_lit", done_cnt, 4);

    // Partial tile interrupted by reset after 4 bytes.
    prep(8'd41, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    feed(4, 1'b0);
    w_valid = 1'b1; w_data = 8'hAA;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_all_zero("midrst");
    tick();
    rst = 1'b0; w_valid = 1'b0; w_data = 8'd0;
    tick();

    // Fresh tile after reset: pad debt cleared, no ALIGN.
    load_tile(8'd51, 1'b0, 1'b0, 1'b0);
    chk("col0_last_lit", log_col[0][2], 57);

    // Padded tile with gaps: 8 stall cycles in FILL.
    load_tile(8'd61, 1'b1, 1'b1, 1'b0);
`ifdef WLC_PERF_CNT_EN
    chk("tile_count", tile_count, tiles_m);
    chk("stall_count", stall_count, stalls_m);
    chk("tile_count_lit", tile_count, 2);
    chk("stall_count_lit", stall_count, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
